// File: rtl/multicyc_arith_unit.sv
// Multi-cycle HI/LO arithmetic unit: MIPS-style multiply, multiply-accumulate,
// radix-2 restoring divide and zero-latency MTHI/MTLO passthrough.
module multicyc_arith_unit #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [63:0] hilo_i,
  output logic        stall,
  output logic [63:0] multicyc_hilo,
  output logic [31:0] multicyc_reg
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_DIV   = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;
  localparam logic [3:0] OP_MTHI  = 4'd10;
  localparam logic [3:0] OP_MTLO  = 4'd11;

  localparam logic [3:0] MUL_LAST = 4'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_LAST = 6'd33;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  op_reg;
  logic [31:0] a_reg, b_reg;
  logic [63:0] hilo_reg;
  logic [31:0] rem_reg, quo_reg, dvs_reg;
  logic [63:0] res_hilo_reg;
  logic [31:0] res_gpr_reg;
  logic [3:0]  mul_cnt_reg;
  logic [5:0]  div_cnt_reg;

  logic is_mul_op, is_div_op, start;
  assign is_mul_op = (op >= OP_MULT) && (op <= OP_MUL);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign start     = req && !flush && (is_mul_op || is_div_op);

  // Multiply on 64-bit extended operands: the low 64 bits are exact for both signednesses
  logic        mul_signed;
  logic [63:0] prod, mul_hilo;
  assign mul_signed = (op_reg == OP_MULT) || (op_reg == OP_MADD) ||
                      (op_reg == OP_MSUB) || (op_reg == OP_MUL);
  assign prod = {{32{mul_signed & a_reg[31]}}, a_reg} *
                {{32{mul_signed & b_reg[31]}}, b_reg};

  always_comb begin
    mul_hilo = hilo_reg;
    case (op_reg)
      OP_MULT, OP_MULTU: mul_hilo = prod;
      OP_MADD, OP_MADDU: mul_hilo = hilo_reg + prod;
      OP_MSUB, OP_MSUBU: mul_hilo = hilo_reg - prod;
      default:           mul_hilo = hilo_reg;
    endcase
  end

  // Restoring divide step on magnitudes; remainder stays below the divisor
  logic        div_signed, quo_neg, rem_neg, div_ge;
  logic [31:0] mag_a, mag_b, rem_step, q_fix, r_fix;
  logic [32:0] shifted;
  logic [63:0] div_hilo;
  assign div_signed = (op_reg == OP_DIV);
  assign quo_neg    = div_signed & (a_reg[31] ^ b_reg[31]);
  assign rem_neg    = div_signed & a_reg[31];
  assign mag_a      = (div_signed && a_reg[31]) ? -a_reg : a_reg;
  assign mag_b      = (div_signed && b_reg[31]) ? -b_reg : b_reg;
  assign shifted    = {rem_reg, quo_reg[31]};
  assign div_ge     = shifted >= {1'b0, dvs_reg};
  assign rem_step   = div_ge ? (shifted[31:0] - dvs_reg) : shifted[31:0];
  assign q_fix      = quo_neg ? -quo_reg : quo_reg;
  assign r_fix      = rem_neg ? -rem_reg : rem_reg;
  assign div_hilo   = (b_reg == 32'd0) ? {a_reg, 32'hFFFF_FFFF} : {r_fix, q_fix};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:     if (start) state_next = is_div_op ? DIV_BUSY : MUL_BUSY;
        MUL_BUSY: if (mul_cnt_reg == MUL_LAST) state_next = DONE;
        DIV_BUSY: if (div_cnt_reg == DIV_LAST) state_next = DONE;
        DONE:     state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      hilo_reg     <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      res_hilo_reg <= '0;
      res_gpr_reg  <= '0;
      mul_cnt_reg  <= '0;
      div_cnt_reg  <= '0;
    end else begin
      mul_cnt_reg <= (state_reg == MUL_BUSY && state_next == MUL_BUSY) ? mul_cnt_reg + 4'd1 : 4'd0;
      div_cnt_reg <= (state_reg == DIV_BUSY && state_next == DIV_BUSY) ? div_cnt_reg + 6'd1 : 6'd0;
      if (state_reg == IDLE && start) begin
        op_reg   <= op;
        a_reg    <= reg1;
        b_reg    <= reg2;
        hilo_reg <= hilo_i;
      end
      if (state_reg == MUL_BUSY) begin
        res_hilo_reg <= mul_hilo;
        res_gpr_reg  <= (op_reg == OP_MUL) ? prod[31:0] : 32'd0;
      end
      // Counter 0: load magnitudes, 1..32: one quotient bit each, 33: sign fix
      if (state_reg == DIV_BUSY) begin
        if (div_cnt_reg == 6'd0) begin
          rem_reg <= '0;
          quo_reg <= mag_a;
          dvs_reg <= mag_b;
        end else if (div_cnt_reg != DIV_LAST) begin
          rem_reg <= rem_step;
          quo_reg <= {quo_reg[30:0], div_ge};
        end else begin
          res_hilo_reg <= div_hilo;
          res_gpr_reg  <= '0;
        end
      end
    end
  end

  always_comb begin
    stall         = 1'b0;
    multicyc_hilo = hilo_i;
    multicyc_reg  = '0;
    case (state_reg)
      IDLE: begin
        stall = start;
        if (req && !flush) begin
          if (op == OP_MTHI)      multicyc_hilo = {reg1, hilo_i[31:0]};
          else if (op == OP_MTLO) multicyc_hilo = {hilo_i[63:32], reg1};
        end
      end
      MUL_BUSY, DIV_BUSY: stall = !flush;
      DONE: begin
        if (!flush) begin
          multicyc_hilo = res_hilo_reg;
          multicyc_reg  = res_gpr_reg;
        end
      end
      default: stall = 1'b0;
    endcase
    if (rst) begin
      stall         = 1'b0;
      multicyc_hilo = hilo_i;
      multicyc_reg  = '0;
    end
  end

endmodule

// File: tb/tb_multicyc_arith_unit.sv
// Testbench for multicyc_arith_unit: vector table driven through a scoreboard
// queue, plus flush / reset / flush-with-req corner sequences.
module tb_multicyc_arith_unit;

  localparam int LAT = 3;
  localparam int DIV_CYC = 34;

  logic        clk = 1'b0;
  logic        rst, flush, req;
  logic [3:0]  op;
  logic [31:0] reg1, reg2;
  logic [63:0] hilo_i;
  logic        stall;
  logic [63:0] multicyc_hilo;
  logic [31:0] multicyc_reg;

  multicyc_arith_unit #(.MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req(req), .op(op),
    .reg1(reg1), .reg2(reg2), .hilo_i(hilo_i),
    .stall(stall), .multicyc_hilo(multicyc_hilo), .multicyc_reg(multicyc_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [63:0] hilo;
    logic [63:0] exp_hilo;
    logic [31:0] exp_reg;
    int          busy;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] exp_hilo;
    logic [31:0] exp_reg;
    int          busy;
  } exp_t;

  vec_t vq[$];
  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [3:0] o, input logic [31:0] r1,
                     input logic [31:0] r2, input logic [63:0] h, input logic [63:0] eh,
                     input logic [31:0] er, input int b);
    vec_t v;
    v.name = n; v.op = o; v.r1 = r1; v.r2 = r2; v.hilo = h;
    v.exp_hilo = eh; v.exp_reg = er; v.busy = b;
    vq.push_back(v);
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   busy;
    int   bad;
    bit   done;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    req = 1'b1; op = v.op; reg1 = v.r1; reg2 = v.r2; hilo_i = v.hilo;
    e.name = v.name; e.exp_hilo = v.exp_hilo; e.exp_reg = v.exp_reg; e.busy = v.busy;
    sb_q.push_back(e);
    #1;
    chk({v.name, "/req_stall"}, 64'(stall), 64'(v.busy != 0));
    busy = 0; bad = 0; done = (v.busy == 0);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); #1;
      if (stall === 1'b1) begin
        busy++;
        if (multicyc_hilo !== hilo_i || multicyc_reg !== 32'd0) bad++;
        reg1 = $urandom; reg2 = $urandom; hilo_i = {$urandom, $urandom};
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s/timeout: stall still high after %0d cycles, required low", v.name, busy);
    end
    e = sb_q.pop_front();
    chk({e.name, "/hilo"}, multicyc_hilo, e.exp_hilo);
    chk({e.name, "/reg"}, {32'd0, multicyc_reg}, {32'd0, e.exp_reg});
    if (e.busy != 0) begin
      chk({e.name, "/busy"}, 64'(busy), 64'(e.busy));
      chk({e.name, "/busy_out"}, 64'(bad), 64'd0);
    end
    $display("txn %s op=%0d hilo=%h reg=%h busy=%0d", e.name, v.op, multicyc_hilo, multicyc_reg, busy);
    req = 1'b0; op = 4'd0; hilo_i = v.hilo;
    @(negedge clk); #1;
    chk({v.name, "/post_stall"}, 64'(stall), 64'd0);
    chk({v.name, "/post_hilo"}, multicyc_hilo, v.hilo);
    chk({v.name, "/post_reg"}, {32'd0, multicyc_reg}, 64'd0);
  endtask

  // Idle window: nothing in flight means no stall and passthrough outputs
  task automatic quiet_window(input string name, input int n);
    int bad = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      hilo_i = {$urandom, $urandom};
      #1;
      if (stall !== 1'b0 || multicyc_hilo !== hilo_i || multicyc_reg !== 32'd0) bad++;
    end
    chk({name, "/quiet"}, 64'(bad), 64'd0);
  endtask

  initial begin
    vec_t v;
    add("divu_100_7",   4'd9, 32'd100,      32'd7,        64'h0, 64'h00000002_0000000E, 32'h0, DIV_CYC);
    add("div_m7_2",     4'd8, 32'hFFFFFFF9, 32'd2,        64'h0, 64'hFFFFFFFF_FFFFFFFD, 32'h0, DIV_CYC);
    add("div_by_zero",  4'd8, 32'hFFFFFFF9, 32'd0,        64'h0, 64'hFFFFFFF9_FFFFFFFF, 32'h0, DIV_CYC);
    add("div_ovf",      4'd8, 32'h80000000, 32'hFFFFFFFF, 64'h0, 64'h00000000_80000000, 32'h0, DIV_CYC);
    add("divu_big",     4'd9, 32'hFFFFFFFF, 32'h10,       64'h0, 64'h0000000F_0FFFFFFF, 32'h0, DIV_CYC);
    add("div_100_m7",   4'd8, 32'd100,      32'hFFFFFFF9, 64'h0, 64'h00000002_FFFFFFF2, 32'h0, DIV_CYC);
    add("div_m100_m7",  4'd8, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'h0, 64'hFFFFFFFE_0000000E, 32'h0, DIV_CYC);
    add("divu_by_zero", 4'd9, 32'd5,        32'd0,        64'h0, 64'h00000005_FFFFFFFF, 32'h0, DIV_CYC);
    add("msubu",        4'd6, 32'd3,        32'd2,        64'h5, 64'hFFFFFFFF_FFFFFFFF, 32'h0, LAT);
    add("mul",          4'd7, 32'hFFFFFFFF, 32'd5, 64'h11112222_33334444, 64'h11112222_33334444, 32'hFFFFFFFB, LAT);
    add("mult_m1_m1",   4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'h00000000_00000001, 32'h0, LAT);
    add("multu_max",    4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFE_00000001, 32'h0, LAT);
    add("mult_min",     4'd1, 32'h80000000, 32'd2,        64'h0, 64'hFFFFFFFF_00000000, 32'h0, LAT);
    add("madd",         4'd3, 32'hFFFFFFFE, 32'd3,        64'h10, 64'h0000000A, 32'h0, LAT);
    add("maddu_wrap",   4'd4, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 32'h0, LAT);
    add("msub",         4'd5, 32'hFFFFFFFE, 32'd3,        64'h100, 64'h106, 32'h0, LAT);
    add("mtlo",  4'd11, 32'h1234,     32'd9, 64'hAAAABBBB_CCCCDDDD, 64'hAAAABBBB_00001234, 32'h0, 0);
    add("mthi",  4'd10, 32'hDEADBEEF, 32'd9, 64'hAAAABBBB_CCCCDDDD, 64'hDEADBEEF_CCCCDDDD, 32'h0, 0);
    add("none",  4'd0,  32'h5555,     32'd9, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 32'h0, 0);
    add("undef", 4'd15, 32'h5555,     32'd9, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 32'h0, 0);

    // Reset dominates a pending divide request
    rst = 1'b1; flush = 1'b0; req = 1'b1; op = 4'd8; reg1 = 32'd7; reg2 = 32'd1;
    hilo_i = 64'hCAFEF00D_12345678;
    repeat (3) @(negedge clk);
    #1;
    chk("reset/stall", 64'(stall), 64'd0);
    chk("reset/hilo", multicyc_hilo, 64'hCAFEF00D_12345678);
    chk("reset/reg", {32'd0, multicyc_reg}, 64'd0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0; op = 4'd0;

    foreach (vq[i]) run_txn(vq[i]);

    // Flush at divide busy cycle 10 discards the operation
    @(negedge clk);
    req = 1'b1; op = 4'd8; reg1 = 32'd1000; reg2 = 32'd3; hilo_i = 64'h0;
    #1 chk("flush/req_stall", 64'(stall), 64'd1);
    repeat (9) @(negedge clk);
    @(negedge clk);
    flush = 1'b1; req = 1'b0;
    #1 chk("flush/stall", 64'(stall), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    quiet_window("flush", 40);
    $display("txn flush_div discarded");
    v.name = "post_flush_mult"; v.op = 4'd1; v.r1 = 32'd2; v.r2 = 32'd3;
    v.hilo = 64'h0; v.exp_hilo = 64'd6; v.exp_reg = 32'd0; v.busy = LAT;
    run_txn(v);

    // Flush together with req in idle starts nothing
    @(negedge clk);
    req = 1'b1; op = 4'd1; reg1 = 32'd2; reg2 = 32'd3; flush = 1'b1; hilo_i = 64'h77;
    #1 chk("flush_req/stall", 64'(stall), 64'd0);
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    quiet_window("flush_req", 10);
    $display("txn flush_with_req ignored");

    // Reset at divide busy cycle 20, then an immediately following DIVU
    @(negedge clk);
    req = 1'b1; op = 4'd8; reg1 = 32'd12345; reg2 = 32'd7; hilo_i = 64'h0;
    #1 chk("rst_mid/req_stall", 64'(stall), 64'd1);
    repeat (20) @(negedge clk);
    rst = 1'b1; req = 1'b0; hilo_i = 64'h13572468_9ABCDEF0;
    #1;
    chk("rst_mid/stall", 64'(stall), 64'd0);
    chk("rst_mid/hilo", multicyc_hilo, 64'h13572468_9ABCDEF0);
    chk("rst_mid/reg", {32'd0, multicyc_reg}, 64'd0);
    $display("txn rst_mid_div aborted");
    v.name = "post_rst_divu"; v.op = 4'd9; v.r1 = 32'd1000; v.r2 = 32'd10;
    v.hilo = 64'h0; v.exp_hilo = 64'h00000000_00000064; v.exp_reg = 32'd0; v.busy = DIV_CYC;
    run_txn(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
